mcd_sync_width_fifo: RTL and testbench
======================================

Name: mcd_sync_width_fifo

Overview:
- Single-clock buffered width converter for the memcached DRAM/SSD data paths, clocked in the clk156 domain.
- Accepts IN_WIDTH words and emits OUT_WIDTH words over valid/ready handshakes, packing (narrow→wide) or unpacking (wide→narrow) with little-endian lane order.
- Generalises the fixed 64→32 / 32→64 FIFOs to any power-of-two width ratio, adds an occupancy count, an almost-full flag and a synchronous flush.

Parameters:
- IN_WIDTH, 64, input data width in bits.
- OUT_WIDTH, 32, output data width in bits. max(IN,OUT)/min(IN,OUT) must be 1, 2, 4 or 8.
- DEPTH, 64, buffer capacity in narrow (N = min(IN_WIDTH,OUT_WIDTH)) lanes. Power of two, ≥ 2·max ratio.
- AFULL_THRESH, 48, almost_full asserts when count ≥ this value (in lanes).

Ports:
- clk156  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents; pointers only.
- s_data  in  IN_WIDTH  input word.
- s_valid  in  1  input word valid.
- s_ready  out  1  block can accept one full input word this cycle.
- m_data  out  OUT_WIDTH  output word.
- m_valid  out  1  output word available.
- m_ready  in  1  consumer accepts m_data.
- count  out  log2(DEPTH)+1  occupancy in narrow lanes.
- almost_full  out  1  count ≥ AFULL_THRESH.

Behaviour:
- Definitions:
  - RI = IN_WIDTH/N lanes per input word; RO = OUT_WIDTH/N lanes per output word.
  - Storage: circular array of DEPTH N-bit lanes, with wr_ptr and rd_ptr in lane units (log2(DEPTH)+1 bits, MSB used as wrap bit).
- Reset (rst=1 at posedge):
  - wr_ptr = rd_ptr = 0, count = 0.
  - s_ready = 0 during the reset cycle, then 1.
  - m_valid = 0, almost_full = 0, m_data = 0.
  - rst has priority over flush and over any handshake in the same cycle.
- Flush: same pointer/count clearing as reset; s_ready stays 1. A handshake coincident with flush is discarded.
- Write:
  - A transfer occurs when s_valid & s_ready.
  - Input lane k (bits [k·N+N-1 : k·N]) is stored at wr_ptr+k, for k = 0..RI-1; wr_ptr then advances by RI (mod 2·DEPTH).
  - s_ready = (DEPTH − count ≥ RI), computed combinationally from registered count.
  - s_data is ignored when s_valid = 0.
- Read:
  - m_valid = (count ≥ RO), from registered count.
  - m_data lane j = storage[rd_ptr+j], for j = 0..RO-1; first-word fall-through with a combinational read of registered storage.
  - On m_valid & m_ready, rd_ptr advances by RO.
  - m_data is stable while m_valid=1 and m_ready=0 (AXI-stream hold rule).
- Latency: an input accepted at edge t raises m_valid after edge t (visible in cycle t+1) provided count ≥ RO. There is no combinational path from s_valid to m_valid, or from m_ready to s_ready.
- Simultaneous read and write: both complete. count_next = count + RI·wr − RO·rd.
- Full/empty: writes are blocked when fewer than RI lanes are free; reads are blocked when fewer than RO lanes are held. Partial lanes (e.g. 1 lane held with RO=2) remain until completed.
- Wrap-around: lane addressing is mod DEPTH, so a wide word may straddle the array end. Correct ordering across the wrap is required.
- almost_full is registered from count_next and asserts in the same cycle count reaches the threshold.
- RI = RO = 1: plain synchronous FIFO of DEPTH words.

Test Plan:
- Reset/idle: hold rst 3 cycles, then release → s_ready=1, m_valid=0, count=0, almost_full=0 on the first cycle after release.
- 64→32 unpack: write 0x1111_2222_3333_4444, m_ready=1 → next cycle m_data=0x3333_4444, following cycle 0x1111_2222, then m_valid=0 and count back to 0.
- 32→64 pack (IN=32, OUT=64): write 0xAAAA0001 then 0xBBBB0002 → m_valid stays 0 after the first write; after the second, m_data=0xBBBB0002_AAAA0001 and count=2.
- Full and backpressure (64→32, DEPTH=64), m_ready=0:
  - Write 32 words → s_ready=0 at count=64; almost_full=1 from count=48.
  - Set m_ready=1 for 1 read → count=63 and s_ready stays 0.
  - Second read → count=62 and s_ready=1.
- Wrap and concurrency: stream 1000 incrementing 64-bit words with random s_valid/m_ready (50%) → output is the exact lane sequence of the input with no loss or duplication, and count matches the scoreboard every cycle.
- Flush mid-operation: with count=10 and simultaneous s_valid/m_ready, pulse flush → next cycle count=0, m_valid=0; the coincident input is dropped; the next write is read back correctly.

Source files
------------

// File: rtl/mcd_sync_width_fifo.sv
// Single-clock width-converting FIFO: packs or unpacks IN_WIDTH words into OUT_WIDTH
// words through a circular store of narrow lanes, little-endian lane order.
module mcd_sync_width_fifo #(
  parameter int IN_WIDTH     = 64,
  parameter int OUT_WIDTH    = 32,
  parameter int DEPTH        = 64,
  parameter int AFULL_THRESH = 48
) (
  input  logic                     clk156,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [IN_WIDTH-1:0]      s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [OUT_WIDTH-1:0]     m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int N  = (IN_WIDTH < OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
  localparam int RI = IN_WIDTH / N;
  localparam int RO = OUT_WIDTH / N;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [N-1:0]         r_mem [DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic                 r_afull;

  logic [PW-1:0]        w_count;
  logic [PW-1:0]        w_free;
  logic [PW-1:0]        w_wr_ptr_next;
  logic [PW-1:0]        w_rd_ptr_next;
  logic [PW-1:0]        w_count_next;
  logic                 w_wr;
  logic                 w_rd;
  logic [OUT_WIDTH-1:0] w_rdata;

  // Occupancy falls out of the wrap-bit pointers, so no separate counter can drift.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_free  = PW'(DEPTH) - w_count;

  assign s_ready = ~rst & (w_free >= PW'(RI));
  assign m_valid = (w_count >= PW'(RO));
  assign w_wr    = s_valid & s_ready & ~flush;
  assign w_rd    = m_valid & m_ready;

  always_comb begin
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    if (w_wr) w_wr_ptr_next = r_wr_ptr + PW'(RI);
    if (w_rd) w_rd_ptr_next = r_rd_ptr + PW'(RO);
    if (flush) begin
      w_wr_ptr_next = '0;
      w_rd_ptr_next = '0;
    end
  end

  assign w_count_next = w_wr_ptr_next - w_rd_ptr_next;

  always_ff @(posedge clk156) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_afull  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_afull  <= (int'(w_count_next) >= AFULL_THRESH);
    end
  end

  // Lane storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk156) begin
    if (w_wr) begin
      for (int k = 0; k < RI; k++) begin
        r_mem[r_wr_ptr[AW-1:0] + AW'(k)] <= s_data[k*N +: N];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RO; gi++) begin : g_rd_lane
      logic [AW-1:0] w_addr;
      assign w_addr                = r_rd_ptr[AW-1:0] + AW'(gi);
      assign w_rdata[gi*N +: N]    = r_mem[w_addr];
    end
  endgenerate

  // Output is forced to zero when nothing is presented so it never shows stale lanes.
  assign m_data      = m_valid ? w_rdata : '0;
  assign count       = w_count;
  assign almost_full = r_afull;

endmodule

// File: tb/tb_mcd_sync_width_fifo.sv
// Bench for mcd_sync_width_fifo: a 64->32 instance against a lane-queue model,
// plus a 32->64 instance for the packing direction.
module tb_mcd_sync_width_fifo;

  logic        clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  // 64 -> 32 instance
  logic        rst, flush, s_valid, s_ready, m_valid, m_ready, almost_full;
  logic [63:0] s_data;
  logic [31:0] m_data;
  logic [6:0]  count;

  // 32 -> 64 instance
  logic        p_rst, p_flush, p_s_valid, p_s_ready, p_m_valid, p_m_ready, p_almost_full;
  logic [31:0] p_s_data;
  logic [63:0] p_m_data;
  logic [6:0]  p_count;

  mcd_sync_width_fifo #(.IN_WIDTH(64), .OUT_WIDTH(32), .DEPTH(64), .AFULL_THRESH(48)) dut (
    .clk156(clk156), .rst(rst), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .count(count), .almost_full(almost_full)
  );

  mcd_sync_width_fifo #(.IN_WIDTH(32), .OUT_WIDTH(64), .DEPTH(64), .AFULL_THRESH(48)) dut_p (
    .clk156(clk156), .rst(p_rst), .flush(p_flush),
    .s_data(p_s_data), .s_valid(p_s_valid), .s_ready(p_s_ready),
    .m_data(p_m_data), .m_valid(p_m_valid), .m_ready(p_m_ready),
    .count(p_count), .almost_full(p_almost_full)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference: the buffer is just an ordered list of 32-bit lanes.
  logic [31:0] mq[$];

  task automatic cycle();
    @(posedge clk156);
    #1;
  endtask

  task automatic push_word(input logic [63:0] w);
    mq.push_back(w[31:0]);
    mq.push_back(w[63:32]);
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; s_valid = 0; m_ready = 0; s_data = '0;
    p_rst = 1; p_flush = 0; p_s_valid = 0; p_m_ready = 0; p_s_data = '0;
    cycle();
    vectors++;
    if (s_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_sready_low got %b want 0", s_ready);
    end
    cycle(); cycle();
    rst = 0; p_rst = 0;
    mq.delete();
    #1;
    vectors++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || count !== 7'd0 || almost_full !== 1'b0 || m_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state got rdy=%b val=%b cnt=%0d af=%b data=%h want 1 0 0 0 0",
               s_ready, m_valid, count, almost_full, m_data);
    end
    vectors++;
    if (p_s_ready !== 1'b1 || p_m_valid !== 1'b0 || p_count !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_pack got rdy=%b val=%b cnt=%0d want 1 0 0", p_s_ready, p_m_valid, p_count);
    end
    $display("reset: released");
  endtask

  task automatic test_unpack();
    s_data = 64'h1111_2222_3333_4444; s_valid = 1; m_ready = 1;
    cycle();
    s_valid = 0;
    $display("unpack: wrote %h", 64'h1111_2222_3333_4444);
    vectors++;
    if (m_valid !== 1'b1 || m_data !== 32'h3333_4444 || count !== 7'd2) begin
      miscompares++;
      $display("FAIL unpack_lane0 got val=%b data=%h cnt=%0d want 1 33334444 2", m_valid, m_data, count);
    end
    cycle();
    vectors++;
    if (m_valid !== 1'b1 || m_data !== 32'h1111_2222 || count !== 7'd1) begin
      miscompares++;
      $display("FAIL unpack_lane1 got val=%b data=%h cnt=%0d want 1 11112222 1", m_valid, m_data, count);
    end
    cycle();
    m_ready = 0;
    vectors++;
    if (m_valid !== 1'b0 || count !== 7'd0) begin
      miscompares++;
      $display("FAIL unpack_empty got val=%b cnt=%0d want 0 0", m_valid, count);
    end
  endtask

  task automatic test_pack();
    p_s_data = 32'hAAAA_0001; p_s_valid = 1;
    cycle();
    $display("pack: wrote %h", 32'hAAAA_0001);
    vectors++;
    if (p_m_valid !== 1'b0 || p_count !== 7'd1) begin
      miscompares++;
      $display("FAIL pack_partial got val=%b cnt=%0d want 0 1", p_m_valid, p_count);
    end
    p_s_data = 32'hBBBB_0002;
    cycle();
    p_s_valid = 0;
    $display("pack: wrote %h", 32'hBBBB_0002);
    vectors++;
    if (p_m_valid !== 1'b1 || p_m_data !== 64'hBBBB_0002_AAAA_0001 || p_count !== 7'd2) begin
      miscompares++;
      $display("FAIL pack_word got val=%b data=%h cnt=%0d want 1 bbbb0002aaaa0001 2", p_m_valid, p_m_data, p_count);
    end
    p_m_ready = 1;
    cycle();
    p_m_ready = 0;
    vectors++;
    if (p_m_valid !== 1'b0 || p_count !== 7'd0) begin
      miscompares++;
      $display("FAIL pack_drain got val=%b cnt=%0d want 0 0", p_m_valid, p_count);
    end
  endtask

  task automatic test_full_backpressure();
    logic [63:0] w;
    m_ready = 0;
    for (int i = 0; i < 32; i++) begin
      w = {$urandom, $urandom};
      s_data = w; s_valid = 1;
      vectors++;
      if (s_ready !== 1'b1) begin
        miscompares++; $display("FAIL full_sready_early word %0d got %b want 1", i, s_ready);
      end
      cycle();
      push_word(w);
      $display("full: wrote %h cnt=%0d", w, mq.size());
      vectors++;
      if (count !== 7'(mq.size()) || almost_full !== (mq.size() >= 48)) begin
        miscompares++;
        $display("FAIL full_count word %0d got cnt=%0d af=%b want %0d %b",
                 i, count, almost_full, mq.size(), mq.size() >= 48);
      end
    end
    s_valid = 0;
    vectors++;
    if (s_ready !== 1'b0 || count !== 7'd64 || almost_full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_state got rdy=%b cnt=%0d af=%b want 0 64 1", s_ready, count, almost_full);
    end
    for (int r = 0; r < 2; r++) begin
      vectors++;
      if (m_data !== mq[0]) begin
        miscompares++; $display("FAIL full_read%0d_data got %h want %h", r, m_data, mq[0]);
      end
      m_ready = 1;
      cycle();
      m_ready = 0;
      void'(mq.pop_front());
      $display("full: read lane, cnt=%0d", mq.size());
      vectors++;
      if (count !== 7'(mq.size()) || s_ready !== (mq.size() <= 62)) begin
        miscompares++;
        $display("FAIL full_read%0d got cnt=%0d rdy=%b want %0d %b", r, count, s_ready, mq.size(), mq.size() <= 62);
      end
    end
  endtask

  task automatic test_wrap_concurrency();
    int unsigned written = 0;
    int unsigned cyc = 0;
    logic exp_rdy, exp_val, do_wr, do_rd;
    logic [63:0] next_word = 64'h0000_0001_0000_0000;
    while ((written < 1000 || mq.size() > 0) && cyc < 20000) begin
      cyc++;
      exp_rdy = (64 - mq.size()) >= 2;
      exp_val = mq.size() >= 1;
      if (written < 1000) begin
        s_valid = ($urandom % 2) == 1;
        m_ready = ($urandom % 2) == 1;
      end else begin
        s_valid = 0;
        m_ready = 1;
      end
      s_data = next_word;
      #1;
      vectors++;
      if (s_ready !== exp_rdy || m_valid !== exp_val || count !== 7'(mq.size()) ||
          almost_full !== (mq.size() >= 48)) begin
        miscompares++;
        $display("FAIL wrap_status cyc %0d got rdy=%b val=%b cnt=%0d af=%b want %b %b %0d %b",
                 cyc, s_ready, m_valid, count, almost_full, exp_rdy, exp_val, mq.size(), mq.size() >= 48);
      end
      if (exp_val) begin
        vectors++;
        if (m_data !== mq[0]) begin
          miscompares++; $display("FAIL wrap_data cyc %0d got %h want %h", cyc, m_data, mq[0]);
        end
      end
      do_wr = s_valid && exp_rdy;
      do_rd = m_ready && exp_val;
      cycle();
      if (do_rd) begin
        $display("wrap: read %h", mq[0]);
        void'(mq.pop_front());
      end
      if (do_wr) begin
        $display("wrap: wrote %h", next_word);
        push_word(next_word);
        next_word = next_word + 64'h0000_0002_0000_0002;
        written++;
      end
    end
    s_valid = 0; m_ready = 0;
    vectors++;
    if (cyc >= 20000) begin
      miscompares++; $display("FAIL wrap_timeout got %0d cycles want < 20000", cyc);
    end
  endtask

  task automatic test_flush();
    logic [63:0] w;
    for (int i = 0; i < 5; i++) begin
      w = {$urandom, $urandom};
      s_data = w; s_valid = 1;
      cycle();
      push_word(w);
    end
    s_valid = 0;
    vectors++;
    if (count !== 7'd10) begin
      miscompares++; $display("FAIL flush_precount got %0d want 10", count);
    end
    s_data = 64'hDEAD_BEEF_DEAD_BEEF; s_valid = 1; m_ready = 1; flush = 1;
    #1;
    vectors++;
    if (s_ready !== 1'b1) begin
      miscompares++; $display("FAIL flush_sready got %b want 1", s_ready);
    end
    cycle();
    flush = 0; s_valid = 0; m_ready = 0;
    mq.delete();
    $display("flush: pulsed");
    vectors++;
    if (count !== 7'd0 || m_valid !== 1'b0 || almost_full !== 1'b0 || s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_state got cnt=%0d val=%b af=%b rdy=%b want 0 0 0 1", count, m_valid, almost_full, s_ready);
    end
    w = 64'h0123_4567_89AB_CDEF;
    s_data = w; s_valid = 1;
    cycle();
    s_valid = 0;
    push_word(w);
    $display("flush: wrote %h", w);
    vectors++;
    if (count !== 7'd2 || m_data !== mq[0]) begin
      miscompares++; $display("FAIL flush_after_lane0 got cnt=%0d data=%h want 2 %h", count, m_data, mq[0]);
    end
    m_ready = 1;
    cycle();
    void'(mq.pop_front());
    vectors++;
    if (m_data !== mq[0]) begin
      miscompares++; $display("FAIL flush_after_lane1 got %h want %h", m_data, mq[0]);
    end
    cycle();
    m_ready = 0;
    void'(mq.pop_front());
    vectors++;
    if (count !== 7'd0 || m_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_drain got cnt=%0d val=%b want 0 0", count, m_valid);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_unpack();
    test_pack();
    test_full_backpressure();
    test_wrap_concurrency();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
